// File: rtl/ch_readout_sequencer_pkg.sv
// rtl/ch_readout_sequencer_pkg.sv - channel state, readout FSM and sampling-mode types
package ch_readout_sequencer_pkg;

    typedef enum logic [2:0] {
        STATE_INIT             = 3'd0,
        STATE_IDLE             = 3'd1,
        STATE_SAMPLING_A       = 3'd2,
        STATE_SAMPLING_A_AND_B = 3'd3,
        STATE_SAMPLING_ALL     = 3'd4,
        STATE_READOUT          = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RO_IDLE  = 2'd0,
        RO_LOAD  = 2'd1,
        RO_ISSUE = 2'd2,
        RO_DONE  = 2'd3
    } ro_state_t;

    typedef enum logic [1:0] {
        MODE_W1 = 2'd0,
        MODE_W2 = 2'd1,
        MODE_W4 = 2'd2
    } ro_mode_t;

    // Segments that fit in the four A..D banks for a given banks-per-segment mode.
    function automatic logic [2:0] mode_seg_limit(input ro_mode_t m);
        case (m)
            MODE_W2: return 3'd2;
            MODE_W4: return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] mode_width(input ro_mode_t m);
        case (m)
            MODE_W2: return 3'd2;
            MODE_W4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ch_readout_sequencer_state_sync.sv
// rtl/ch_readout_sequencer_state_sync.sv - two-stage capture of channel state with stability flag
module ch_state_sync
    import ch_readout_sequencer_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  state_t state_i,
    output state_t stable_state_o,
    output logic   stable_valid_o
);

    state_t s1_q;
    state_t s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= STATE_INIT;
            s2_q <= STATE_INIT;
        end else begin
            s1_q <= state_i;
            s2_q <= s1_q;
        end
    end

    // A value is trusted only once it has been seen on two consecutive cycles.
    assign stable_state_o = s2_q;
    assign stable_valid_o = (s1_q == s2_q);

endmodule

// File: rtl/ch_readout_sequencer.sv
// rtl/ch_readout_sequencer.sv - walks captured bank/cell addresses on readout; PSEC_RO_INCLUDE_BANK_E_EN adds bank E
module ch_readout_sequencer
    import ch_readout_sequencer_pkg::*;
#(
    parameter  int NUM_BANKS      = 5,
    parameter  int CELLS_PER_BANK = 256,
    localparam int CELL_W         = $clog2(CELLS_PER_BANK)
) (
    input  logic              FCLK,
    input  logic              RSTB,
    input  state_t            current_state,
    input  logic [2:0]        trigger_cnt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [2:0]        rd_bank,
    output logic [CELL_W-1:0] rd_cell,
    output logic              rd_last,
    output logic              readout_done,
    output logic              cnt_err
);

    localparam logic [CELL_W-1:0] CELL_MAX = CELL_W'(CELLS_PER_BANK - 1);
`ifdef PSEC_RO_INCLUDE_BANK_E_EN
    localparam logic [3:0] BANK_CAP = 4'(NUM_BANKS);
`else
    localparam logic [3:0] BANK_CAP = 4'(NUM_BANKS - 1);
`endif

    state_t            stable_state;
    logic              stable_valid;
    ro_state_t         st_q;
    ro_mode_t          mode_q, mode_d;
    logic              ro_flag_q, ro_flag_d, ro_rise;
    logic [2:0]        last_bank_q;
    logic              valid_q, last_q, done_q, err_q;
    logic [2:0]        bank_q;
    logic [CELL_W-1:0] cell_q;

    logic [2:0]        seg_lim, segs_d;
    logic              clamp;
    logic [3:0]        banks_raw, banks_d;
    logic [CELL_W-1:0] cell_nxt;
    logic [2:0]        bank_nxt;
    logic              last_nxt;

    ch_state_sync u_sync (
        .clk_i          (FCLK),
        .rst_ni         (RSTB),
        .state_i        (current_state),
        .stable_state_o (stable_state),
        .stable_valid_o (stable_valid)
    );

    // While the synchroniser disagrees, the readout flag holds its last trusted value.
    assign ro_flag_d = stable_valid ? (stable_state == STATE_READOUT) : ro_flag_q;
    assign ro_rise   = ro_flag_d & ~ro_flag_q;

    always_comb begin
        mode_d = mode_q;
        if (stable_valid) begin
            case (stable_state)
                STATE_SAMPLING_A:       mode_d = MODE_W1;
                STATE_SAMPLING_A_AND_B: mode_d = MODE_W2;
                STATE_SAMPLING_ALL:     mode_d = MODE_W4;
                default:                mode_d = mode_q;
            endcase
        end
    end

    always_comb begin
        seg_lim   = mode_seg_limit(mode_q);
        clamp     = (trigger_cnt > seg_lim);
        segs_d    = clamp ? seg_lim : trigger_cnt;
        banks_raw = 4'(segs_d) * 4'(mode_width(mode_q));
`ifdef PSEC_RO_INCLUDE_BANK_E_EN
        if (segs_d == seg_lim) banks_raw = banks_raw + 4'd1;
`endif
        banks_d   = (banks_raw > BANK_CAP) ? BANK_CAP : banks_raw;
    end

    always_comb begin
        cell_nxt = cell_q + 1'b1;
        bank_nxt = (cell_q == CELL_MAX) ? bank_q + 3'd1 : bank_q;
        last_nxt = (bank_nxt == last_bank_q) && (cell_nxt == CELL_MAX);
    end

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            st_q        <= RO_IDLE;
            mode_q      <= MODE_W1;
            ro_flag_q   <= 1'b0;
            last_bank_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bank_q      <= '0;
            cell_q      <= '0;
        end else begin
            ro_flag_q <= ro_flag_d;
            mode_q    <= mode_d;
            done_q    <= 1'b0;
            case (st_q)
                RO_IDLE: begin
                    if (ro_rise) st_q <= RO_LOAD;
                end
                RO_LOAD: begin
                    if (!ro_flag_d) begin
                        st_q <= RO_IDLE;
                    end else begin
                        if (clamp) err_q <= 1'b1;
                        last_bank_q <= 3'(banks_d - 4'd1);
                        bank_q      <= '0;
                        cell_q      <= '0;
                        last_q      <= 1'b0;
                        if (segs_d == 3'd0) begin
                            st_q   <= RO_DONE;
                            done_q <= 1'b1;
                        end else begin
                            st_q    <= RO_ISSUE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RO_ISSUE: begin
                    if (!ro_flag_d) begin
                        st_q    <= RO_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        bank_q  <= '0;
                        cell_q  <= '0;
                    end else if (rd_ready) begin
                        if (last_q) begin
                            st_q    <= RO_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            last_q  <= 1'b0;
                            bank_q  <= '0;
                            cell_q  <= '0;
                        end else begin
                            cell_q <= cell_nxt;
                            bank_q <= bank_nxt;
                            last_q <= last_nxt;
                        end
                    end
                end
                RO_DONE: st_q <= RO_IDLE;
                default: st_q <= RO_IDLE;
            endcase
        end
    end

    assign rd_valid     = valid_q;
    assign rd_bank      = bank_q;
    assign rd_cell      = cell_q;
    assign rd_last      = last_q;
    assign readout_done = done_q;
    assign cnt_err      = err_q;

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// tb/tb_ch_readout_sequencer.sv - randomized self-checking bench for ch_readout_sequencer
module tb_ch_readout_sequencer;
    import ch_readout_sequencer_pkg::*;

    localparam int CELLS = 4;
    localparam int CW    = $clog2(CELLS);

    logic          FCLK = 1'b0;
    logic          RSTB;
    state_t        current_state;
    logic [2:0]    trigger_cnt;
    logic          rd_valid, rd_ready, rd_last, readout_done, cnt_err;
    logic [2:0]    rd_bank;
    logic [CW-1:0] rd_cell;

    int n_checks = 0;
    int n_errors = 0;
    int model_w  = 1;
    bit model_err = 1'b0;
    int first_cyc, done_cyc;

    always #5 FCLK = ~FCLK;

    ch_readout_sequencer #(.NUM_BANKS(5), .CELLS_PER_BANK(CELLS)) dut (
        .FCLK          (FCLK),
        .RSTB          (RSTB),
        .current_state (current_state),
        .trigger_cnt   (trigger_cnt),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_bank       (rd_bank),
        .rd_cell       (rd_cell),
        .rd_last       (rd_last),
        .readout_done  (readout_done),
        .cnt_err       (cnt_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready always, 1 ready toggles, 2 ready random with pct%; abort_at<0 means no abort.
    task automatic run_readout(input state_t samp, input int tc, input int rmode, input int pct,
                               input int abort_at, input string tag,
                               output int first_c, output int done_c);
        int q_bank[$];
        int q_cell[$];
        int lim, segs, nbanks, eb, ec, accepted, abort_cyc, done_cnt, tail;
        bit aborted, held;
        logic [2:0] hb;
        logic [CW-1:0] hc;
        accepted = 0; abort_cyc = 0; done_cnt = 0; tail = 0; aborted = 0; held = 0;
        hb = '0; hc = '0;
        first_c = -1; done_c = -1;
        current_state = samp;
        repeat (4) @(negedge FCLK);
        case (samp)
            STATE_SAMPLING_A:       model_w = 1;
            STATE_SAMPLING_A_AND_B: model_w = 2;
            STATE_SAMPLING_ALL:     model_w = 4;
            default: ;
        endcase
        lim  = 4 / model_w;
        segs = (tc > lim) ? lim : tc;
        if (tc > lim) model_err = 1'b1;
        nbanks = segs * model_w;
`ifdef PSEC_RO_INCLUDE_BANK_E_EN
        if (segs == lim) nbanks++;
`endif
        for (int b = 0; b < nbanks; b++)
            for (int c = 0; c < CELLS; c++) begin
                q_bank.push_back(b);
                q_cell.push_back(c);
            end
        trigger_cnt   = 3'(tc);
        current_state = STATE_READOUT;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge FCLK);
            if (abort_at >= 0 && !aborted && accepted == abort_at) begin
                aborted = 1; abort_cyc = cyc; current_state = STATE_INIT;
            end
            if (aborted) rd_ready = 1'b0;
            else case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 2 == 0);
                default: rd_ready = ($urandom_range(99) < pct);
            endcase
            if (readout_done) begin
                done_cnt++; done_c = cyc;
                chk({tag, "_done_after_all"}, q_bank.size(), 0);
            end
            if (aborted && cyc == abort_cyc + 2) chk({tag, "_abort_hold"}, rd_valid, 1);
            if (aborted && cyc == abort_cyc + 3) chk({tag, "_abort_drop"}, rd_valid, 0);
            if (held && !aborted) begin
                chk({tag, "_hold_valid"}, rd_valid, 1);
                chk({tag, "_hold_addr"}, {rd_bank, rd_cell}, {hb, hc});
            end
            held = 0;
            if (rd_valid && !aborted) begin
                if (first_c < 0) first_c = cyc;
                if (rd_ready) begin
                    if (q_bank.size() == 0) chk({tag, "_extra_beat"}, rd_valid, 0);
                    else begin
                        eb = q_bank.pop_front();
                        ec = q_cell.pop_front();
                        chk({tag, "_bank"}, rd_bank, eb);
                        chk({tag, "_cell"}, rd_cell, ec);
                        chk({tag, "_last"}, rd_last, q_bank.size() == 0);
                        accepted++;
                    end
                end else begin
                    held = 1; hb = rd_bank; hc = rd_cell;
                end
            end
            if (aborted && cyc >= abort_cyc + 8) break;
            if (done_cnt > 0) tail++;
            if (tail >= 4) break;
        end
        rd_ready = 1'b0;
        if (aborted) chk({tag, "_abort_no_done"}, done_cnt, 0);
        else begin
            chk({tag, "_done_count"}, done_cnt, 1);
            chk({tag, "_beats_left"}, q_bank.size(), 0);
        end
        chk({tag, "_cnt_err"}, cnt_err, model_err);
    endtask

    function automatic state_t pick_state(input int k);
        case (k)
            0:       return STATE_SAMPLING_A;
            1:       return STATE_SAMPLING_A_AND_B;
            2:       return STATE_SAMPLING_ALL;
            default: return STATE_IDLE;
        endcase
    endfunction

    initial begin
        bit seen_v, seen_d;
        RSTB = 1'b0; current_state = STATE_INIT; trigger_cnt = '0; rd_ready = 1'b0;
        repeat (2) @(negedge FCLK);
        chk("rst_valid", rd_valid, 0);
        chk("rst_bank", rd_bank, 0);
        chk("rst_cell", rd_cell, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_done", readout_done, 0);
        chk("rst_err", cnt_err, 0);
        RSTB = 1'b1;
        @(negedge FCLK);

        run_readout(STATE_SAMPLING_A, 2, 0, 100, -1, "w1_seg2", first_cyc, done_cyc);
        chk("w1_first_latency", first_cyc, 3);
        run_readout(STATE_SAMPLING_A_AND_B, 1, 1, 50, -1, "w2_toggle", first_cyc, done_cyc);
        run_readout(STATE_SAMPLING_ALL, 3, 0, 100, -1, "w4_clamp", first_cyc, done_cyc);
        run_readout(STATE_IDLE, 0, 0, 100, -1, "zero_seg", first_cyc, done_cyc);
        chk("zero_done_latency", done_cyc, 3);
        run_readout(STATE_SAMPLING_A, 2, 0, 100, 5, "abort", first_cyc, done_cyc);
        run_readout(STATE_INIT, 2, 2, 70, -1, "restart", first_cyc, done_cyc);

        current_state = STATE_SAMPLING_A;
        repeat (4) @(negedge FCLK);
        current_state = STATE_READOUT;
        @(negedge FCLK);
        current_state = STATE_SAMPLING_A;
        seen_v = 0; seen_d = 0;
        repeat (8) begin
            @(negedge FCLK);
            seen_v |= rd_valid;
            seen_d |= readout_done;
        end
        chk("glitch_valid", seen_v, 0);
        chk("glitch_done", seen_d, 0);

        for (int i = 0; i < 8; i++)
            run_readout(pick_state($urandom_range(3)), $urandom_range(7), 2,
                        $urandom_range(100, 30), -1, "rand", first_cyc, done_cyc);

        current_state = STATE_SAMPLING_ALL; trigger_cnt = 3'd1;
        repeat (4) @(negedge FCLK);
        current_state = STATE_READOUT; rd_ready = 1'b1;
        for (int i = 0; i < 10 && !rd_valid; i++) @(negedge FCLK);
        chk("mid_valid", rd_valid, 1);
        repeat (5) @(negedge FCLK);
        RSTB = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_bank", rd_bank, 0);
        chk("arst_cell", rd_cell, 0);
        chk("arst_last", rd_last, 0);
        chk("arst_done", readout_done, 0);
        chk("arst_err", cnt_err, 0);
        rd_ready = 1'b0;
        repeat (2) @(negedge FCLK);
        RSTB = 1'b1;
        model_w = 1; model_err = 1'b0;
        run_readout(STATE_INIT, 4, 0, 100, -1, "post_rst_w1", first_cyc, done_cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
